// File: rtl/n64adv2_hdmi_clksel_seq_pkg.sv
// -----------------------------------------------------------------------------
// n64adv2_hdmi_clksel_seq_pkg
// Shared definitions for the HDMI clock-select sequencer:
//   - state encoding of the sequencer FSM (3 bits)
//   - default cycle counts for request qualification, reset hold and settle
//   - small helper used to size the shared cycle counter
// -----------------------------------------------------------------------------
package n64adv2_hdmi_clksel_seq_pkg;

   // Default timing (system clock cycles)
   localparam int STABLE_CYCLES_DEF = 16;
   localparam int HOLD_CYCLES_DEF   = 64;
   localparam int SETTLE_CYCLES_DEF = 256;

   // INIT waits this many cycles so the synchronizer output is valid
   localparam int INIT_WAIT_CYCLES  = 2;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_QUAL   = 3'd2,
      ST_HOLD   = 3'd3,
      ST_SWITCH = 3'd4,
      ST_SETTLE = 3'd5
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/n64adv2_hdmi_clksel_seq_sync2.sv
// -----------------------------------------------------------------------------
// n64adv2_sync2
// Generic 2-flop synchronizer, asynchronous active-low reset, reset value 0.
// Ports:
//   clk_i    in   destination clock
//   rst_n_i  in   asynchronous active-low reset
//   d_i      in   asynchronous input (W bits)
//   q_o      out  synchronized output, 2 cycles latency
// -----------------------------------------------------------------------------
module n64adv2_sync2 #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/n64adv2_hdmi_clksel_seq.sv
// -----------------------------------------------------------------------------
// n64adv2_hdmi_clksel_seq
// Sequences a glitch-safe switch between the HDMI main and sub pixel clocks.
// The HDMI domain is held in reset around every select change; reset is only
// released once the new clock has settled and the transmitter is configured.
// Runs entirely in the SYS_CLK_i domain.
//
// Ports:
//   SYS_CLK_i        in   system clock
//   nRST_i           in   asynchronous active-low reset
//   sel_req_i        in   requested select (1 = sub clock), asynchronous
//   cfg_done_i       in   HDMI transmitter configured (level)
//   clksel_o         out  registered select to the clock-control block
//   hdmi_nrst_req_o  out  registered active-low HDMI reset request
//   busy_o           out  high whenever the FSM is not in IDLE
//   switch_cnt_o     out  completed switches (8 bit, saturating)
//   state_dbg_o      out  current FSM state (debug)
//
// Build option:
//   N64ADV2_CLKSEL_SWITCH_COUNT_EN  defined: switch_cnt_o counts completed
//                                   switches, saturating at 8'hFF.
//                                   undefined: switch_cnt_o tied to 8'h00.
// -----------------------------------------------------------------------------
module n64adv2_hdmi_clksel_seq
   import n64adv2_hdmi_clksel_seq_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic       SYS_CLK_i,
   input  logic       nRST_i,
   input  logic       sel_req_i,
   input  logic       cfg_done_i,
   output logic       clksel_o,
   output logic       hdmi_nrst_req_o,
   output logic       busy_o,
   output logic [7:0] switch_cnt_o,
   output logic [2:0] state_dbg_o
);

   // The counter must also reach the INIT wait, which matters only when all
   // three cycle parameters are tiny.
   localparam int CNT_MAX = max_int(max_int(STABLE_CYCLES, HOLD_CYCLES),
                                    max_int(SETTLE_CYCLES, INIT_WAIT_CYCLES));
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Terminal values: the counter starts at 0 on state entry, so the exit
   // edge is the one where the counter already holds N-1.
   localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_WAIT_CYCLES);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   logic             sel_sync;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             clksel_q;
   logic             hdmi_nrst_q;
   logic             busy_q;

   n64adv2_sync2 #(
      .W (1)
   ) u_sync_sel (
      .clk_i   (SYS_CLK_i),
      .rst_n_i (nRST_i),
      .d_i     (sel_req_i),
      .q_o     (sel_sync)
   );

   // Sequencer FSM. busy_q is written together with every state change so it
   // is always equal to (state_q != ST_IDLE) without a decode after the flop.
   always_ff @(posedge SYS_CLK_i or negedge nRST_i) begin
      if (!nRST_i) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         clksel_q    <= 1'b0;
         hdmi_nrst_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (cnt_q == INIT_LAST) begin
                  clksel_q <= sel_sync;
                  state_q  <= ST_SETTLE;
                  cnt_q    <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            ST_IDLE: begin
               if (!cfg_done_i) begin
                  // Transmitter lost its configuration: re-enter reset and
                  // wait for it via the normal settle path.
                  hdmi_nrst_q <= 1'b0;
                  state_q     <= ST_SETTLE;
                  cnt_q       <= '0;
                  busy_q      <= 1'b1;
               end else if (sel_sync != clksel_q) begin
                  state_q <= ST_QUAL;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end

            ST_QUAL: begin
               if (sel_sync == clksel_q) begin
                  // Glitch on the request: drop it without touching reset.
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == STABLE_LAST) begin
                  hdmi_nrst_q <= 1'b0;
                  state_q     <= ST_HOLD;
                  cnt_q       <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            ST_HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  state_q <= ST_SWITCH;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            ST_SWITCH: begin
               clksel_q <= ~clksel_q;
               state_q  <= ST_SETTLE;
               cnt_q    <= '0;
            end

            ST_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  // Count stays saturated until the transmitter is ready.
                  if (cfg_done_i) begin
                     hdmi_nrst_q <= 1'b1;
                     state_q     <= ST_IDLE;
                     cnt_q       <= '0;
                     busy_q      <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end

            default: begin
               hdmi_nrst_q <= 1'b0;
               state_q     <= ST_INIT;
               cnt_q       <= '0;
               busy_q      <= 1'b1;
            end
         endcase
      end
   end

`ifdef N64ADV2_CLKSEL_SWITCH_COUNT_EN
   logic [7:0] switch_cnt_q;
   logic [7:0] switch_cnt_d;

   // Counts on the SWITCH edge, the same edge clksel_o toggles.
   always_comb begin
      switch_cnt_d = switch_cnt_q;
      if ((state_q == ST_SWITCH) && (switch_cnt_q != 8'hFF)) begin
         switch_cnt_d = switch_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge SYS_CLK_i or negedge nRST_i) begin
      if (!nRST_i) begin
         switch_cnt_q <= 8'h00;
      end else begin
         switch_cnt_q <= switch_cnt_d;
      end
   end

   assign switch_cnt_o = switch_cnt_q;
`else
   assign switch_cnt_o = 8'h00;
`endif

   assign clksel_o        = clksel_q;
   assign hdmi_nrst_req_o = hdmi_nrst_q;
   assign busy_o          = busy_q;
   assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_n64adv2_hdmi_clksel_seq.sv
// -----------------------------------------------------------------------------
// tb_n64adv2_hdmi_clksel_seq
// Directed bench for the HDMI clock-select sequencer (STABLE=4, HOLD=8,
// SETTLE=16). Every expected output change is queued as {edge number, outputs};
// the monitor pops one entry each time the output vector changes and checks
// both the value and the edge on which it changed. Edge numbers count rising
// edges of the clock; inputs change on falling edges.
// -----------------------------------------------------------------------------
module tb_n64adv2_hdmi_clksel_seq;
   import n64adv2_hdmi_clksel_seq_pkg::*;

   localparam int STABLE = 4;
   localparam int HOLD   = 8;
   localparam int SETTLE = 16;

`ifdef N64ADV2_CLKSEL_SWITCH_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       rst_n;
   logic       sel_req;
   logic       cfg_done;
   logic       clksel;
   logic       hdmi_nrst;
   logic       busy;
   logic [7:0] switch_cnt;
   logic [2:0] state_dbg;

   int cyc = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   n64adv2_hdmi_clksel_seq #(
      .STABLE_CYCLES (STABLE),
      .HOLD_CYCLES   (HOLD),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .SYS_CLK_i       (clk),
      .nRST_i          (rst_n),
      .sel_req_i       (sel_req),
      .cfg_done_i      (cfg_done),
      .clksel_o        (clksel),
      .hdmi_nrst_req_o (hdmi_nrst),
      .busy_o          (busy),
      .switch_cnt_o    (switch_cnt),
      .state_dbg_o     (state_dbg)
   );

   // ---------------- scoreboard ----------------
   // entry = {edge[31:0], clksel, hdmi_nrst, busy, switch_cnt[7:0]}
   logic [42:0] exp_q[$];
   logic [10:0] mon_last;
   logic [10:0] mon_cur;
   logic [42:0] mon_e;
   bit          mon_en = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;

   function automatic logic [7:0] ec(input int n);
      return CNT_EN ? n[7:0] : 8'h00;
   endfunction

   task automatic push(input int c, input logic cs, input logic nr,
                       input logic bz, input int n);
      exp_q.push_back({c[31:0], cs, nr, bz, ec(n)});
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: pops one expectation per observed output change.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_cur = {clksel, hdmi_nrst, busy, switch_cnt};
         if (mon_cur !== mon_last) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change: edge %0d outputs %b, no change expected",
                        cyc, mon_cur);
            end else begin
               mon_e = exp_q.pop_front();
               if ((mon_e[42:11] != 32'(cyc)) || (mon_e[10:0] !== mon_cur)) begin
                  n_fail++;
                  $display("FAIL output_change: edge %0d outputs %b, expected edge %0d outputs %b",
                           cyc, mon_cur, mon_e[42:11], mon_e[10:0]);
               end
            end
            mon_last = mon_cur;
         end
      end
   end

   // ---------------- stimulus ----------------
   int r;

   initial begin
      sel_req  = 1'b0;
      cfg_done = 1'b1;
      rst_n    = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("rst_clksel", 32'(clksel), 32'd0);
      check("rst_nrst",   32'(hdmi_nrst), 32'd0);
      check("rst_busy",   32'(busy), 32'd1);
      check("rst_cnt",    32'(switch_cnt), 32'd0);
      check("rst_state",  32'(state_dbg), 32'(ST_INIT));
      mon_last = {1'b0, 1'b0, 1'b1, 8'h00};
      mon_en   = 1'b1;

      // 1: reset release, select 0 loaded on edge 3, reset released on edge 19
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      r = cyc;
      push(r + 19, 1'b0, 1'b1, 1'b0, 0);
      wait_until(r + 4);
      check("init_state_settle", 32'(state_dbg), 32'(ST_SETTLE));
      wait_until(r + 26);

      // 3: 3-cycle request pulse: QUAL entered, then dropped without reset
      r = cyc;
      sel_req = 1'b1;
      push(r + 3, 1'b0, 1'b1, 1'b1, 0);
      push(r + 6, 1'b0, 1'b1, 1'b0, 0);
      wait_until(r + 3);
      sel_req = 1'b0;
      wait_until(r + 4);
      check("pulse_state_qual", 32'(state_dbg), 32'(ST_QUAL));
      wait_until(r + 12);

      // 4: cfg_done low for 40 cycles; release 1 edge after it returns
      r = cyc;
      cfg_done = 1'b0;
      push(r + 1, 1'b0, 1'b0, 1'b1, 0);
      wait_until(r + 40);
      cfg_done = 1'b1;
      push(r + 41, 1'b0, 1'b1, 1'b0, 0);
      wait_until(r + 46);

      // 5: request 1 then back to 0 during HOLD: two full switches
      r = cyc;
      sel_req = 1'b1;
      push(r + 3, 1'b0, 1'b1, 1'b1, 0);
      push(r + 7, 1'b0, 1'b0, 1'b1, 0);
      wait_until(r + 8);
      check("toggle_state_hold", 32'(state_dbg), 32'(ST_HOLD));
      sel_req = 1'b0;
      push(r + 16, 1'b1, 1'b0, 1'b1, 1);
      push(r + 32, 1'b1, 1'b1, 1'b0, 1);
      push(r + 33, 1'b1, 1'b1, 1'b1, 1);
      push(r + 37, 1'b1, 1'b0, 1'b1, 1);
      push(r + 46, 1'b0, 1'b0, 1'b1, 2);
      push(r + 62, 1'b0, 1'b1, 0, 2);
      wait_until(r + 70);

      // 2 + 6: switch to 1, then assert reset in the middle of SETTLE
      r = cyc;
      sel_req = 1'b1;
      push(r + 3, 1'b0, 1'b1, 1'b1, 2);
      push(r + 7, 1'b0, 1'b0, 1'b1, 2);
      push(r + 16, 1'b1, 1'b0, 1'b1, 3);
      wait_until(r + 22);
      check("switch_state_settle", 32'(state_dbg), 32'(ST_SETTLE));
      // Async reset: the monitor sees the change at the next falling edge.
      push(r + 23, 1'b0, 1'b0, 1'b1, 0);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_clksel", 32'(clksel), 32'd0);
      check("async_rst_nrst",   32'(hdmi_nrst), 32'd0);
      check("async_rst_busy",   32'(busy), 32'd1);
      check("async_rst_cnt",    32'(switch_cnt), 32'd0);
      check("async_rst_state",  32'(state_dbg), 32'(ST_INIT));
      wait_until(r + 25);

      // Release with sel_req still 1: INIT loads select 1 on edge 3
      rst_n = 1'b1;
      r = cyc;
      push(r + 3, 1'b1, 1'b0, 1'b1, 0);
      push(r + 19, 1'b1, 1'b1, 1'b0, 0);
      wait_until(r + 25);

      mon_en = 1'b0;
      while (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missing_change: expected edge %0d outputs %b never observed",
                  mon_e[42:11], mon_e[10:0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
